// File: rtl/comptest_pkg.sv
// Shared definitions for the comparator test board: address width default,
// scan sequencer state encoding and modulo address addition.
package comptest_pkg;

  localparam int ADR_W_DEFAULT = 4;
  localparam int ADR_MAX_W     = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SETTLE,
    S_FIRE,
    S_HOLD,
    S_DONE
  } scan_state_t;

  // Callers truncate the result to their own address width, which supplies the wrap.
  function automatic logic [ADR_MAX_W-1:0] adr_add(input logic [ADR_MAX_W-1:0] a,
                                                   input logic [ADR_MAX_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/cycle_down_counter.sv
// Loadable down counter that stops at zero; used for the settle and hold timers.
module cycle_down_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Channel sweep sequencer driving the high/med/low pulse-injection mux addresses.
// Optional build macro MUX_SCAN_CONFLICT_CHECK_EN adds conflict_err and skips conflicting channels.
module mux_scan_sequencer
  import comptest_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int HOLD_CYCLES   = 4,
  parameter int ADR_W         = ADR_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [ADR_W-1:0] first_ch,
  input  logic [ADR_W-1:0] last_ch,
  input  logic [ADR_W-1:0] med_offset,
  input  logic [ADR_W-1:0] high_offset,
  input  logic [7:0]       repeat_cnt,
  output logic [ADR_W-1:0] low_adr,
  output logic [ADR_W-1:0] med_adr,
  output logic [ADR_W-1:0] high_adr,
  output logic             mux_en,
  output logic             pulse,
  output logic             busy,
  output logic             done
`ifdef MUX_SCAN_CONFLICT_CHECK_EN
  ,
  output logic             conflict_err
`endif
);

  localparam int CNT_W = 16;
  // Timers hold the number of cycles remaining after the current one, so the
  // state is left on the cycle the counter reads zero.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);

  scan_state_t      state;
  logic [ADR_W-1:0] last_cfg;
  logic [ADR_W-1:0] med_off_cfg;
  logic [ADR_W-1:0] high_off_cfg;
  logic [7:0]       rep_cfg;
  logic [7:0]       pulses_left;
  logic [7:0]       rep_eff;
  logic [ADR_W-1:0] low_next;
  logic             settle_zero;
  logic             hold_zero;
  logic             chan_end;

  function automatic logic [ADR_W-1:0] wrap_add(input logic [ADR_W-1:0] a,
                                                input logic [ADR_W-1:0] b);
    return ADR_W'(adr_add(ADR_MAX_W'(a), ADR_MAX_W'(b)));
  endfunction

  assign rep_eff  = (repeat_cnt == 8'd0) ? 8'd1 : repeat_cnt;
  assign low_next = wrap_add(low_adr, ADR_W'(1));

  cycle_down_counter #(.W(CNT_W)) u_settle_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (state == S_SETUP),
    .load_val (SETTLE_LOAD),
    .en       (state == S_SETTLE),
    .zero     (settle_zero)
  );

  cycle_down_counter #(.W(CNT_W)) u_hold_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (state == S_FIRE),
    .load_val (HOLD_LOAD),
    .en       (state == S_HOLD),
    .zero     (hold_zero)
  );

  // A channel ends after its last hold, or straight from SETUP when its addresses collide.
  always_comb begin
    chan_end = (state == S_HOLD) && hold_zero && (pulses_left == 8'd0);
`ifdef MUX_SCAN_CONFLICT_CHECK_EN
    if ((state == S_SETUP) &&
        ((low_adr == med_adr) || (low_adr == high_adr) || (med_adr == high_adr))) begin
      chan_end = 1'b1;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      low_adr      <= '0;
      med_adr      <= '0;
      high_adr     <= '0;
      mux_en       <= 1'b0;
      pulse        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pulses_left  <= 8'd0;
`ifdef MUX_SCAN_CONFLICT_CHECK_EN
      conflict_err <= 1'b0;
`endif
    end else begin
      pulse <= 1'b0;
      done  <= 1'b0;
      if (abort) begin
        // Addresses deliberately keep their last value on abort.
        state  <= S_IDLE;
        mux_en <= 1'b0;
        busy   <= 1'b0;
      end else if (chan_end) begin
        mux_en <= 1'b0;
`ifdef MUX_SCAN_CONFLICT_CHECK_EN
        if (state == S_SETUP) begin
          conflict_err <= 1'b1;
        end
`endif
        if (low_adr == last_cfg) begin
          state <= S_DONE;
          done  <= 1'b1;
        end else begin
          state       <= S_SETUP;
          low_adr     <= low_next;
          med_adr     <= wrap_add(low_next, med_off_cfg);
          high_adr    <= wrap_add(low_next, high_off_cfg);
          pulses_left <= rep_cfg;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state        <= S_SETUP;
              busy         <= 1'b1;
              mux_en       <= 1'b0;
              last_cfg     <= last_ch;
              med_off_cfg  <= med_offset;
              high_off_cfg <= high_offset;
              rep_cfg      <= rep_eff;
              pulses_left  <= rep_eff;
              low_adr      <= first_ch;
              med_adr      <= wrap_add(first_ch, med_offset);
              high_adr     <= wrap_add(first_ch, high_offset);
`ifdef MUX_SCAN_CONFLICT_CHECK_EN
              conflict_err <= 1'b0;
`endif
            end
          end
          S_SETUP: begin
            state  <= S_SETTLE;
            mux_en <= 1'b1;
          end
          S_SETTLE: begin
            if (settle_zero) begin
              state <= S_FIRE;
              pulse <= 1'b1;
            end
          end
          S_FIRE: begin
            state       <= S_HOLD;
            pulses_left <= pulses_left - 8'd1;
          end
          S_HOLD: begin
            if (hold_zero) begin
              state <= S_FIRE;
              pulse <= 1'b1;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state  <= S_IDLE;
            mux_en <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed table-driven bench for mux_scan_sequencer (SETTLE_CYCLES=4, HOLD_CYCLES=2),
// with conflict-check cases when MUX_SCAN_CONFLICT_CHECK_EN is defined.
module tb_mux_scan_sequencer;

  localparam int SETTLE = 4;
  localparam int HOLD   = 2;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic [3:0] first_ch;
  logic [3:0] last_ch;
  logic [3:0] med_offset;
  logic [3:0] high_offset;
  logic [7:0] repeat_cnt;
  logic [3:0] low_adr;
  logic [3:0] med_adr;
  logic [3:0] high_adr;
  logic       mux_en;
  logic       pulse;
  logic       busy;
  logic       done;
`ifdef MUX_SCAN_CONFLICT_CHECK_EN
  logic       conflict_err;
`endif

  int errors = 0;
  int checks = 0;

  mux_scan_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .HOLD_CYCLES   (HOLD),
    .ADR_W         (4)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .first_ch     (first_ch),
    .last_ch      (last_ch),
    .med_offset   (med_offset),
    .high_offset  (high_offset),
    .repeat_cnt   (repeat_cnt),
    .low_adr      (low_adr),
    .med_adr      (med_adr),
    .high_adr     (high_adr),
    .mux_en       (mux_en),
    .pulse        (pulse),
    .busy         (busy),
    .done         (done)
`ifdef MUX_SCAN_CONFLICT_CHECK_EN
    ,
    .conflict_err (conflict_err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Channel addresses are packed one nibble per channel, channel 0 in [3:0].
  typedef struct {
    logic [3:0]  first;
    logic [3:0]  last;
    logic [3:0]  med_off;
    logic [3:0]  high_off;
    logic [7:0]  rep;
    int          nch;
    int          exp_pulses;
    int          exp_first_pulse;
    int          exp_done_c;
    logic [15:0] exp_low;
    logic [15:0] exp_med;
    logic [15:0] exp_high;
    bit          poke;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start a scan, scramble the config inputs, and compare every cycle until idle.
  task automatic run_scan(input vec_t v);
    int rep_eff, per, dc, npulse, first_pc, done_pc, ctrl_bad, r, idx;
    logic e_busy, e_done, e_mux, e_pulse;
    logic [3:0] pl[16];
    logic [3:0] pm[16];
    logic [3:0] ph[16];
    rep_eff  = (v.rep == 8'd0) ? 1 : int'(v.rep);
    per      = 1 + SETTLE + rep_eff * (1 + HOLD);
    dc       = 1 + v.nch * per;
    npulse   = 0;
    first_pc = -1;
    done_pc  = -1;
    ctrl_bad = 0;
    for (int i = 0; i < 16; i++) begin
      pl[i] = 'x; pm[i] = 'x; ph[i] = 'x;
    end
    @(negedge clock);
    first_ch    = v.first;
    last_ch     = v.last;
    med_offset  = v.med_off;
    high_offset = v.high_off;
    repeat_cnt  = v.rep;
    start       = 1'b1;
    @(negedge clock);
    start       = 1'b0;
    first_ch    = ~v.first;
    last_ch     = v.last + 4'd7;
    med_offset  = v.med_off + 4'd3;
    high_offset = 4'd0;
    repeat_cnt  = 8'd9;
    for (int c = 1; c <= dc + 1; c++) begin
      if (c > 1) @(negedge clock);
      if (v.poke && c == 10) start = 1'b1;
      if (v.poke && c == 12) start = 1'b0;
      r       = (c - 1) % per;
      e_busy  = (c <= dc);
      e_done  = (c == dc);
      e_mux   = (c < dc) && (r != 0);
      e_pulse = (c < dc) && (r >= 1 + SETTLE) && (((r - 1 - SETTLE) % (1 + HOLD)) == 0);
      if ({busy, done, mux_en, pulse} !== {e_busy, e_done, e_mux, e_pulse}) ctrl_bad++;
      if (pulse === 1'b1) begin
        if (npulse < 16) begin
          pl[npulse] = low_adr; pm[npulse] = med_adr; ph[npulse] = high_adr;
        end
        if (npulse == 0) first_pc = c;
        npulse++;
      end
      if (done === 1'b1) done_pc = c;
    end
    check("pulse_count", npulse, v.exp_pulses);
    check("first_pulse_cycle", first_pc, v.exp_first_pulse);
    check("done_cycle", done_pc, v.exp_done_c);
    check("ctrl_sequence_bad_cycles", ctrl_bad, 0);
    for (int ch = 0; ch < v.nch; ch++) begin
      idx = ch * rep_eff;
      if (idx < 16) begin
        check("chan_low_adr", {28'd0, pl[idx]}, {28'd0, v.exp_low[ch*4 +: 4]});
        check("chan_med_adr", {28'd0, pm[idx]}, {28'd0, v.exp_med[ch*4 +: 4]});
        check("chan_high_adr", {28'd0, ph[idx]}, {28'd0, v.exp_high[ch*4 +: 4]});
      end
    end
  endtask

  initial begin
    int np, nd, nm;
    vecs[0] = '{first:4'd3, last:4'd5, med_off:4'd1, high_off:4'd2, rep:8'd2, nch:3,
                exp_pulses:6, exp_first_pulse:6, exp_done_c:34,
                exp_low:16'h0543, exp_med:16'h0654, exp_high:16'h0765, poke:1'b0};
    vecs[1] = '{first:4'd14, last:4'd1, med_off:4'd1, high_off:4'd2, rep:8'd0, nch:4,
                exp_pulses:4, exp_first_pulse:6, exp_done_c:33,
                exp_low:16'h10FE, exp_med:16'h210F, exp_high:16'h3210, poke:1'b0};
    vecs[2] = '{first:4'd7, last:4'd7, med_off:4'd3, high_off:4'd5, rep:8'd3, nch:1,
                exp_pulses:3, exp_first_pulse:6, exp_done_c:15,
                exp_low:16'h0007, exp_med:16'h000A, exp_high:16'h000C, poke:1'b0};
    vecs[3] = '{first:4'd3, last:4'd5, med_off:4'd1, high_off:4'd2, rep:8'd2, nch:3,
                exp_pulses:6, exp_first_pulse:6, exp_done_c:34,
                exp_low:16'h0543, exp_med:16'h0654, exp_high:16'h0765, poke:1'b1};

    reset_n = 1'b0; start = 1'b1; abort = 1'b0;
    first_ch = 4'd9; last_ch = 4'd2; med_offset = 4'd1; high_offset = 4'd2; repeat_cnt = 8'd1;
    repeat (3) @(negedge clock);
    check("reset_low_adr", {28'd0, low_adr}, 32'd0);
    check("reset_med_adr", {28'd0, med_adr}, 32'd0);
    check("reset_high_adr", {28'd0, high_adr}, 32'd0);
    check("reset_ctrl", {28'd0, mux_en, pulse, busy, done}, 32'd0);
`ifdef MUX_SCAN_CONFLICT_CHECK_EN
    check("reset_conflict_err", {31'd0, conflict_err}, 32'd0);
`endif
    reset_n = 1'b1; start = 1'b0;
    @(negedge clock);
    check("idle_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 4; i++) run_scan(vecs[i]);

    // Abort during SETTLE of the second channel (cycle 14 of the basic scan).
    @(negedge clock);
    first_ch = 4'd3; last_ch = 4'd5; med_offset = 4'd1; high_offset = 4'd2; repeat_cnt = 8'd2;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    np = 0;
    for (int c = 1; c < 14; c++) begin
      if (pulse === 1'b1) np++;
      @(negedge clock);
    end
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_mux_en", {31'd0, mux_en}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_low_hold", {28'd0, low_adr}, 32'd4);
    check("abort_pulses_before", np, 2);
    np = 0; nd = 0; nm = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (pulse === 1'b1) np++;
      if (done === 1'b1) nd++;
      if (mux_en === 1'b1 || busy === 1'b1) nm++;
    end
    check("abort_quiet_pulses", np, 0);
    check("abort_quiet_done", nd, 0);
    check("abort_quiet_active", nm, 0);
    run_scan(vecs[0]);

    // Start and abort together in IDLE.
    @(negedge clock);
    start = 1'b1; abort = 1'b1;
    @(negedge clock);
    check("start_abort_busy", {31'd0, busy}, 32'd0);
    check("start_abort_mux_en", {31'd0, mux_en}, 32'd0);
    start = 1'b0; abort = 1'b0;
    @(negedge clock);
    check("start_abort_busy_later", {31'd0, busy}, 32'd0);

    // Reset in the middle of a scan.
    @(negedge clock);
    first_ch = 4'd14; last_ch = 4'd1; med_offset = 4'd1; high_offset = 4'd2; repeat_cnt = 8'd0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check("midreset_ctrl", {28'd0, mux_en, pulse, busy, done}, 32'd0);
    check("midreset_adrs", {20'd0, low_adr, med_adr, high_adr}, 32'd0);

`ifdef MUX_SCAN_CONFLICT_CHECK_EN
    // med_offset 0 collides on every channel: expect done at cycle 4 with no mux activity.
    @(negedge clock);
    first_ch = 4'd2; last_ch = 4'd4; med_offset = 4'd0; high_offset = 4'd5; repeat_cnt = 8'd1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    nm = 0; nd = -1;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) @(negedge clock);
      if (c == 2) check("conflict_err_set", {31'd0, conflict_err}, 32'd1);
      if (mux_en === 1'b1 || pulse === 1'b1) nm++;
      if (done === 1'b1) nd = c;
      if (c == 5) check("conflict_idle_busy", {31'd0, busy}, 32'd0);
    end
    check("conflict_no_mux", nm, 0);
    check("conflict_done_cycle", nd, 4);
    check("conflict_err_sticky", {31'd0, conflict_err}, 32'd1);
    run_scan(vecs[0]);
    check("conflict_err_cleared", {31'd0, conflict_err}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
